// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment reader:
//   - active-low segment patterns for the decimal digits and hex letters
//     (bit 6 = segment a ... bit 0 = segment g, so a literal reads a..g
//     from left to right)
//   - the all-dark blank pattern and the "no digit" code
//   - the output handshake FSM state type
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] DIGIT_NONE = 4'hF;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_lookup.sv
// -----------------------------------------------------------------------------
// seg7_lookup
// Combinational pattern-to-code decoder.
//   pattern_i [6:0] : active-low segments, bit 6 = a ... bit 0 = g
//   code_o    [3:0] : decoded value, 4'hF for blank or illegal patterns
//   blank_o         : pattern is all segments dark
//   illegal_o       : pattern is neither a table entry nor blank
// Build option: define SEG7_READER_HEX_EN to also decode A,b,C,d,E,F to
// 4'hA..4'hF; without it those six patterns are reported illegal.
// -----------------------------------------------------------------------------
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       blank_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = DIGIT_NONE;
        blank_o   = 1'b0;
        illegal_o = 1'b0;
        case (pattern_i)
            SEG_0:     code_o = 4'h0;
            SEG_1:     code_o = 4'h1;
            SEG_2:     code_o = 4'h2;
            SEG_3:     code_o = 4'h3;
            SEG_4:     code_o = 4'h4;
            SEG_5:     code_o = 4'h5;
            SEG_6:     code_o = 4'h6;
            SEG_7:     code_o = 4'h7;
            SEG_8:     code_o = 4'h8;
            SEG_9:     code_o = 4'h9;
            SEG_BLANK: blank_o = 1'b1;
`ifdef SEG7_READER_HEX_EN
            SEG_A:     code_o = 4'hA;
            SEG_B:     code_o = 4'hB;
            SEG_C:     code_o = 4'hC;
            SEG_D:     code_o = 4'hD;
            SEG_E:     code_o = 4'hE;
            SEG_F:     code_o = 4'hF;
`endif
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// -----------------------------------------------------------------------------
// seg7_reader
// Samples an asynchronous active-low seven-segment bus, waits for a pattern
// to be stable for STABLE_CYCLES samples, decodes it and offers it on a
// valid/ready output.
//   CLOCK_50        : only clock, rising edge
//   RESET           : synchronous, active-high
//   SEG_IN    [6:0] : segments, bit 6 = a ... bit 0 = g, 0 = lit
//   OUT_READY       : consumer takes the word
//   OUT_VALID       : DIGIT/BLANK/ILLEGAL hold a new accepted pattern
//   DIGIT     [3:0] : decoded value (4'hF for blank/illegal)
//   BLANK, ILLEGAL  : classification of the accepted pattern
//   OVERRUN         : sticky, an accepted pattern was dropped
//   ERR_CNT   [7:0] : saturating count of delivered illegal patterns
// Build option: SEG7_READER_HEX_EN (applied inside seg7_lookup).
// -----------------------------------------------------------------------------
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [6:0] SEG_IN,
    input  logic       OUT_READY,
    output logic       OUT_VALID,
    output logic [3:0] DIGIT,
    output logic       BLANK,
    output logic       ILLEGAL,
    output logic       OVERRUN,
    output logic [7:0] ERR_CNT
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [6:0] s1_q, s2_q;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] last_q;
    state_t     state_q;
    logic [3:0] digit_q;
    logic       blank_q, illegal_q, overrun_q;
    logic [7:0] err_q;

    logic [3:0] lk_code;
    logic       lk_blank, lk_illegal;
    logic       accept, load, drop;

    // s1_q is the value s2_q takes next, so comparing the two tells whether
    // s2 is about to change; the counter thereby moves on the same edge as s2.
    always_comb begin
        cnt_d = cnt_q;
        if (s1_q != s2_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Accept fires once, on the edge where the counter reaches its limit.
    assign accept = (s1_q == s2_q) && (cnt_q == STABLE_MAX - 8'd1) && (s2_q != last_q);
    assign load   = accept && ((state_q == IDLE) || OUT_READY);
    assign drop   = accept && (state_q == PEND) && !OUT_READY;

    seg7_lookup u_lookup (
        .pattern_i (s2_q),
        .code_o    (lk_code),
        .blank_o   (lk_blank),
        .illegal_o (lk_illegal)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s1_q      <= SEG_BLANK;
            s2_q      <= SEG_BLANK;
            cnt_q     <= 8'd0;
            last_q    <= SEG_BLANK;
            state_q   <= IDLE;
            digit_q   <= DIGIT_NONE;
            blank_q   <= 1'b1;
            illegal_q <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            s1_q  <= SEG_IN;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;

            if (load) begin
                // Covers both a fresh word from IDLE and a back-to-back
                // replacement in the same cycle the previous word is taken.
                digit_q   <= lk_code;
                blank_q   <= lk_blank;
                illegal_q <= lk_illegal;
                last_q    <= s2_q;
                state_q   <= PEND;
                if (lk_illegal && (err_q != 8'hFF)) begin
                    err_q <= err_q + 8'd1;
                end
            end else if ((state_q == PEND) && OUT_READY) begin
                state_q <= IDLE;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign OUT_VALID = (state_q == PEND);
    assign DIGIT     = digit_q;
    assign BLANK     = blank_q;
    assign ILLEGAL   = illegal_q;
    assign OVERRUN   = overrun_q;
    assign ERR_CNT   = err_q;

endmodule
